// File: rtl/riscv_fetch_buffer.sv
// riscv_fetch_buffer
// Pipelined instruction-fetch front end. Issues req/gnt/rvalid fetches to
// instruction memory, keeps up to DEPTH fetches in flight or buffered, and hands
// {pc, instruction} pairs to decode over a valid/ready handshake. A redirect
// flushes the buffer and discards stale responses still returning from memory.
//
// Parameters:
//   WORD_SIZE : width of PC, address and instruction words
//   DEPTH     : buffer slots = max in-flight plus buffered fetches (power of 2, >= 2)
//   RESET_PC  : first fetch address after reset
//
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   imem_req_o / imem_addr_o      fetch request and word-aligned address
//   imem_gnt_i                    request accepted this cycle
//   imem_rvalid_i / imem_rdata_i  in-order response
//   redirect_i / redirect_addr_i  flush and restart fetching at a new PC
//   instr_valid_o / instr_ready_i head-of-buffer handshake to decode
//   instr_o / pc_o                head instruction and its PC (0 when not valid)
//   occupancy_o                   number of allocated slots
//
// Optional build macro RISCV_FETCH_PERF_EN adds saturating counters:
//   stall_cnt_o : cycles with a request pending but not granted
//   flush_cnt_o : cycles with redirect_i asserted

module riscv_fetch_buffer #(
    parameter int unsigned          WORD_SIZE = 32,
    parameter int unsigned          DEPTH     = 4,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    output logic                     imem_req_o,
    output logic [WORD_SIZE-1:0]     imem_addr_o,
    input  logic                     imem_gnt_i,
    input  logic                     imem_rvalid_i,
    input  logic [WORD_SIZE-1:0]     imem_rdata_i,
    input  logic                     redirect_i,
    input  logic [WORD_SIZE-1:0]     redirect_addr_i,
    output logic                     instr_valid_o,
    input  logic                     instr_ready_i,
    output logic [WORD_SIZE-1:0]     instr_o,
    output logic [WORD_SIZE-1:0]     pc_o,
    output logic [$clog2(DEPTH):0]   occupancy_o
`ifdef RISCV_FETCH_PERF_EN
    ,
    output logic [31:0]              stall_cnt_o,
    output logic [31:0]              flush_cnt_o
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam logic [WORD_SIZE-1:0] PC_STEP   = WORD_SIZE'(4);
    localparam logic [WORD_SIZE-1:0] PC_MASK   = ~WORD_SIZE'(3);
    localparam logic [CNT_W:0]       DEPTH_EXT = (CNT_W + 1)'(DEPTH);

    // Fetch stream and slot bookkeeping
    logic [WORD_SIZE-1:0] fetch_pc_q, fetch_pc_d;
    logic [DEPTH-1:0]     filled_q, filled_d;
    ptr_t                 head_q, head_d;      // oldest allocated slot
    ptr_t                 tail_q, tail_d;      // next slot to allocate
    ptr_t                 fill_q, fill_d;      // oldest allocated, unfilled slot
    cnt_t                 alloc_q, alloc_d;    // allocated slots
    cnt_t                 pend_q, pend_d;      // allocated slots awaiting a response
    cnt_t                 discard_q, discard_d; // stale responses still to drop

    // Slot payload; validity lives in filled_q so this needs no reset
    logic [WORD_SIZE-1:0] slot_pc_q    [DEPTH];
    logic [WORD_SIZE-1:0] slot_instr_q [DEPTH];

    logic       grant;
    logic       pop;
    logic       fill;
    logic [CNT_W:0] budget_used;
    cnt_t       in_flight;

    // Low address bits of a redirect target are deliberately ignored
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_addr_i[1:0];

    // Output / handshake decode
    always_comb begin
        budget_used   = {1'b0, alloc_q} + {1'b0, discard_q};
        in_flight     = pend_q + discard_q;
        imem_req_o    = !rst_i && !redirect_i && (budget_used < DEPTH_EXT);
        imem_addr_o   = fetch_pc_q;
        instr_valid_o = filled_q[head_q] && !redirect_i;
        instr_o       = instr_valid_o ? slot_instr_q[head_q] : '0;
        pc_o          = instr_valid_o ? slot_pc_q[head_q] : '0;
        occupancy_o   = alloc_q;
        grant         = imem_req_o && imem_gnt_i;
        pop           = instr_valid_o && instr_ready_i;
        // Responses fill only once every stale response has been dropped
        fill          = imem_rvalid_i && !redirect_i && (discard_q == '0) && (pend_q != '0);
    end

    // Next-state
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        filled_d   = filled_q;
        head_d     = head_q;
        tail_d     = tail_q;
        fill_d     = fill_q;
        alloc_d    = alloc_q;
        pend_d     = pend_q;
        discard_d  = discard_q;

        if (redirect_i) begin
            fetch_pc_d = redirect_addr_i & PC_MASK;
            filled_d   = '0;
            head_d     = '0;
            tail_d     = '0;
            fill_d     = '0;
            alloc_d    = '0;
            pend_d     = '0;
            // Everything still in flight is now stale; a response landing this
            // very cycle is already accounted for.
            if (imem_rvalid_i && (in_flight != '0)) begin
                discard_d = in_flight - cnt_t'(1);
            end else begin
                discard_d = in_flight;
            end
        end else begin
            if (grant) begin
                fetch_pc_d       = fetch_pc_q + PC_STEP;
                filled_d[tail_q] = 1'b0;
                tail_d           = tail_q + ptr_t'(1);
            end
            if (fill) begin
                filled_d[fill_q] = 1'b1;
                fill_d           = fill_q + ptr_t'(1);
            end
            if (pop) begin
                filled_d[head_q] = 1'b0;
                head_d           = head_q + ptr_t'(1);
            end
            if (imem_rvalid_i && (discard_q != '0)) begin
                discard_d = discard_q - cnt_t'(1);
            end
            alloc_d = alloc_q + cnt_t'(grant) - cnt_t'(pop);
            pend_d  = pend_q + cnt_t'(grant) - cnt_t'(fill);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_pc_q <= RESET_PC & PC_MASK;
            filled_q   <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            fill_q     <= '0;
            alloc_q    <= '0;
            pend_q     <= '0;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            filled_q   <= filled_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            fill_q     <= fill_d;
            alloc_q    <= alloc_d;
            pend_q     <= pend_d;
            discard_q  <= discard_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (grant) begin
            slot_pc_q[tail_q] <= fetch_pc_q;
        end
        if (fill) begin
            slot_instr_q[fill_q] <= imem_rdata_i;
        end
    end

`ifdef RISCV_FETCH_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (imem_req_o && !imem_gnt_i && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (redirect_i && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

`ifndef SYNTHESIS
    // A response must belong to some granted, not yet returned request
    rvalid_has_owner: assert property (@(posedge clk_i) disable iff (rst_i)
        imem_rvalid_i |-> (in_flight != '0));
`endif

endmodule

// File: tb/tb_riscv_fetch_buffer.sv
module tb_riscv_fetch_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req;
    logic [31:0] addr;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_addr = '0;
    logic        valid;
    logic        ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [2:0]  occ;

    // Second instance exercising PC wrap-around; never gets responses
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [31:0] w_pc;
    logic [2:0]  w_occ;

`ifdef RISCV_FETCH_PERF_EN
    logic [31:0] stall_cnt, flush_cnt, w_stall_cnt, w_flush_cnt;
`endif

    always #5 clk = ~clk;

    riscv_fetch_buffer #(.WORD_SIZE(32), .DEPTH(4), .RESET_PC(32'h0000_0100)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .imem_req_o      (req),
        .imem_addr_o     (addr),
        .imem_gnt_i      (gnt),
        .imem_rvalid_i   (rvalid),
        .imem_rdata_i    (rdata),
        .redirect_i      (redirect),
        .redirect_addr_i (redirect_addr),
        .instr_valid_o   (valid),
        .instr_ready_i   (ready),
        .instr_o         (instr),
        .pc_o            (pc),
        .occupancy_o     (occ)
`ifdef RISCV_FETCH_PERF_EN
        ,
        .stall_cnt_o     (stall_cnt),
        .flush_cnt_o     (flush_cnt)
`endif
    );

    riscv_fetch_buffer #(.WORD_SIZE(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk_i           (clk),
        .rst_i           (rst),
        .imem_req_o      (w_req),
        .imem_addr_o     (w_addr),
        .imem_gnt_i      (gnt),
        .imem_rvalid_i   (1'b0),
        .imem_rdata_i    (32'h0),
        .redirect_i      (1'b0),
        .redirect_addr_i (32'h0),
        .instr_valid_o   (w_valid),
        .instr_ready_i   (1'b0),
        .instr_o         (w_instr),
        .pc_o            (w_pc),
        .occupancy_o     (w_occ)
`ifdef RISCV_FETCH_PERF_EN
        ,
        .stall_cnt_o     (w_stall_cnt),
        .flush_cnt_o     (w_flush_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    bit          mem_en = 1'b1;
    logic [31:0] resp_q [$];   // addresses granted, awaiting a memory response
    logic [63:0] exp_q  [$];   // expected {pc, instr} in delivery order
    int          occ_model = 0;
    logic [31:0] model_pc = 32'h100;

    logic        s_req, s_valid, s_wreq;
    logic [31:0] s_addr, s_pc, s_instr, s_waddr;
    logic [2:0]  s_occ;

    typedef struct {
        bit          rst_first;
        bit          gnt;
        bit          ready;
        bit          exp_req;
        logic [31:0] exp_addr;
        bit          exp_valid;
        logic [31:0] exp_pc;
        logic [2:0]  exp_occ;
    } vec_t;

    vec_t vecs [15];

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs at negedge, sample #1 later, update models
    task automatic cycle(input logic g, input logic r, input logic rd, input logic [31:0] ra);
        logic [63:0] e;
        @(negedge clk);
        gnt           = g;
        ready         = r;
        redirect      = rd;
        redirect_addr = ra;
        if (mem_en && resp_q.size() > 0) begin
            rvalid = 1'b1;
            rdata  = instr_of(resp_q[0]);
        end else begin
            rvalid = 1'b0;
            rdata  = '0;
        end
        #1;
        s_req   = req;
        s_addr  = addr;
        s_valid = valid;
        s_pc    = pc;
        s_instr = instr;
        s_occ   = occ;
        s_wreq  = w_req;
        s_waddr = w_addr;

        check("occupancy", {29'b0, s_occ}, occ_model);
        if (!s_valid) begin
            check("idle_instr_zero", s_instr, 32'h0);
            check("idle_pc_zero", s_pc, 32'h0);
        end
        if (rd) begin
            check("redirect_req_low", {31'b0, s_req}, 32'h0);
            check("redirect_valid_low", {31'b0, s_valid}, 32'h0);
        end
        if (rvalid) void'(resp_q.pop_front());

        if (rd) begin
            exp_q.delete();
            occ_model = 0;
            model_pc  = ra & 32'hFFFF_FFFC;
        end else begin
            if (s_valid && r) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL pop_unexpected: got pc %h, expected no instruction", s_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("pop_pc", s_pc, e[63:32]);
                    check("pop_instr", s_instr, e[31:0]);
                end
                occ_model--;
            end
            if (s_req && g) begin
                check("grant_addr", s_addr, model_pc);
                resp_q.push_back(s_addr);
                exp_q.push_back({model_pc, instr_of(model_pc)});
                model_pc = model_pc + 32'd4;
                occ_model++;
            end
        end
    endtask

    task automatic clear_models();
        resp_q.delete();
        exp_q.delete();
        occ_model = 0;
        model_pc  = 32'h100;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        gnt      = 1'b0;
        ready    = 1'b0;
        redirect = 1'b0;
        rvalid   = 1'b0;
        rdata    = '0;
        mem_en   = 1'b1;
        clear_models();
        #1;
        check("rst_req", {31'b0, req}, 32'h0);
        check("rst_valid", {31'b0, valid}, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc", pc, 32'h0);
        check("rst_occ", {29'b0, occ}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 32'h0);
            if (s_valid) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL wait_valid: got no instr_valid_o, expected one within %0d cycles",
                     budget);
        end
    endtask

    initial begin
        bit found;

        // Streaming with an always-ready consumer, then a stalled consumer
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0,   3'd0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h104, 1'b0, 32'h0,   3'd1};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h108, 1'b1, 32'h100, 3'd2};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h10C, 1'b1, 32'h104, 3'd2};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h110, 1'b1, 32'h108, 3'd2};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h114, 1'b1, 32'h10C, 3'd2};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0,   3'd0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h104, 1'b0, 32'h0,   3'd1};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h108, 1'b1, 32'h100, 3'd2};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h10C, 1'b1, 32'h100, 3'd3};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 3'd4};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 3'd4};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 3'd4};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h110, 1'b1, 32'h104, 3'd3};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 3'd4};

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].rst_first) do_reset();
            cycle(vecs[i].gnt, vecs[i].ready, 1'b0, 32'h0);
            check($sformatf("vec%0d_req", i), {31'b0, s_req}, {31'b0, vecs[i].exp_req});
            if (vecs[i].exp_req) check($sformatf("vec%0d_addr", i), s_addr, vecs[i].exp_addr);
            check($sformatf("vec%0d_valid", i), {31'b0, s_valid}, {31'b0, vecs[i].exp_valid});
            check($sformatf("vec%0d_pc", i), s_pc, vecs[i].exp_pc);
            check($sformatf("vec%0d_occ", i), {29'b0, s_occ}, {29'b0, vecs[i].exp_occ});
        end

        // Redirect with two fetches outstanding; both stale responses dropped
        do_reset();
        mem_en = 1'b0;
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b1, 32'h0000_2003);
        mem_en = 1'b1;
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check("redir_req", {31'b0, s_req}, 32'h1);
        check("redir_addr", s_addr, 32'h0000_2000);
        wait_valid(8, found);
        if (found) check("redir_first_pc", s_pc, 32'h0000_2000);

        // Redirect coinciding with rvalid, valid and ready
        do_reset();
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        mem_en = 1'b0;
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("full_req", {31'b0, s_req}, 32'h0);
        check("full_head_pc", s_pc, 32'h100);
        mem_en = 1'b1;
        check("coinc_rvalid_pending", resp_q.size(), 32'd2);
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_3000);
        check("coinc_valid", {31'b0, s_valid}, 32'h0);
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check("coinc_req", {31'b0, s_req}, 32'h1);
        check("coinc_addr", s_addr, 32'h0000_3000);
        check("coinc_occ", {29'b0, s_occ}, 32'h0);
        wait_valid(8, found);
        if (found) check("coinc_first_pc", s_pc, 32'h0000_3000);

        // Fetch PC wrap-around
        do_reset();
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("wrap_req0", {31'b0, s_wreq}, 32'h1);
        check("wrap_addr0", s_waddr, 32'hFFFF_FFFC);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("wrap_req1", {31'b0, s_wreq}, 32'h1);
        check("wrap_addr1", s_waddr, 32'h0000_0000);

        // Asynchronous reset pulse between clock edges, mid-stream
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        #1;
        rst    = 1'b1;
        gnt    = 1'b0;
        ready  = 1'b0;
        rvalid = 1'b0;
        rdata  = '0;
        #1;
        check("pulse_req", {31'b0, req}, 32'h0);
        check("pulse_valid", {31'b0, valid}, 32'h0);
        check("pulse_instr", instr, 32'h0);
        check("pulse_pc", pc, 32'h0);
        check("pulse_occ", {29'b0, occ}, 32'h0);
        rst = 1'b0;
        clear_models();
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check("pulse_restart_req", {31'b0, s_req}, 32'h1);
        check("pulse_restart_addr", s_addr, 32'h100);
        wait_valid(8, found);
        if (found) check("pulse_first_pc", s_pc, 32'h100);

        // Random traffic with occasional redirects
        do_reset();
        for (int i = 0; i < 400; i++) begin
            mem_en = ($urandom_range(0, 3) != 0);
            cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 39) == 0), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
